// File: rtl/miner_dispatch.sv
// miner_dispatch: header intake, nonce-chunk dispatch to a hasher bank,
// found-nonce and completion reporting over AXI-Stream.
module miner_dispatch #(
  parameter int N_HASHERS  = 2,
  parameter int HDR_WORDS  = 19,
  parameter int CHUNK_LOG2 = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [31:0]               s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic [31:0]               m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic [32*HDR_WORDS-1:0]   hdr_o,
  output logic [N_HASHERS-1:0]      hs_start,
  output logic [32*N_HASHERS-1:0]   hs_nonce_base,
  input  logic [N_HASHERS-1:0]      hs_done,
  input  logic [N_HASHERS-1:0]      hs_found,
  input  logic [32*N_HASHERS-1:0]   hs_nonce
);
  localparam int N  = N_HASHERS;
  localparam int IW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
  localparam logic [32:0] CHUNK = 33'd1 << CHUNK_LOG2;

  typedef enum logic [2:0] {
    IDLE, LOAD, DISPATCH, DRAIN, REPORT, FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0] widx;
  logic [7:0]    job_id;
  logic [7:0]    found_cnt;
  logic [7:0]    drop_cnt;
  logic [32:0]   next_base;
  logic [31:0]   issued;
  logic          err_q;
  logic          abort_q;
  logic [N-1:0]  outstanding;
  logic [N-1:0]  pending;
  logic [31:0]   nonce_q [N];
  logic          pkt_rep;
  logic [3:0]    pkt_idx;

  logic          beat, last_word, hdr_end, hdr_ok;
  logic          m_hs, m_end, rep_done;
  logic [32:0]   base_nxt;
  logic [N-1:0]  free, start_oh, pend_oh, pclr, drop;
  logic [3:0]    pend_idx;
  logic [31:0]   sel_nonce;
  logic [8:0]    found_sum, drop_sum;
  logic [3:0]    rtype;

  assign beat      = s_tvalid & s_tready;
  assign last_word = widx == IW'(HDR_WORDS - 1);
  assign hdr_end   = beat & (state == IDLE || state == LOAD)
                   & (last_word | s_tlast);
  assign hdr_ok    = last_word & s_tlast;

  // lowest-index idle hasher; freed hashers show up one cycle after done
  assign free     = ~outstanding;
  assign start_oh = (state == DISPATCH) ? (free & (~free + N'(1))) : '0;
  assign hs_start = start_oh;
  assign base_nxt = next_base + CHUNK;

  assign pend_oh  = pending & (~pending + N'(1));
  assign m_hs     = m_tvalid & m_tready;
  assign m_end    = m_hs & m_tlast;
  assign rep_done = m_end & pkt_rep;
  assign drop     = hs_found & pending & ~pclr;
  assign busy_o   = state != IDLE;
  assign rtype    = err_q ? 4'h3 : (abort_q ? 4'h4 : 4'h2);

  always_comb begin
    pend_idx  = '0;
    sel_nonce = '0;
    found_sum = {1'b0, found_cnt};
    drop_sum  = {1'b0, drop_cnt};
    for (int i = 0; i < N; i++) begin
      pclr[i] = m_end & ~pkt_rep & (pkt_idx == 4'(i));
      hs_nonce_base[32*i +: 32] = start_oh[i] ? next_base[31:0] : 32'd0;
      if (pend_oh[i]) pend_idx = 4'(i);
      if (pkt_idx == 4'(i)) sel_nonce = nonce_q[i];
      found_sum = found_sum + 9'(hs_found[i]);
      drop_sum  = drop_sum + 9'(drop[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, LOAD:
        if (beat) begin
          if (hdr_end)
            state_nxt = hdr_ok ? DISPATCH : (s_tlast ? REPORT : FLUSH);
          else
            state_nxt = LOAD;
        end
      DISPATCH:
        if (abort_i || (|start_oh && base_nxt[32])) state_nxt = DRAIN;
      DRAIN:
        if (outstanding == '0 && pending == '0 && !m_tvalid)
          state_nxt = REPORT;
      REPORT:
        if (rep_done) state_nxt = IDLE;
      FLUSH:
        if (beat && s_tlast) state_nxt = REPORT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_tready    <= 1'b0;
      hdr_o       <= '0;
      widx        <= '0;
      job_id      <= 8'hFF;
      found_cnt   <= '0;
      drop_cnt    <= '0;
      next_base   <= '0;
      issued      <= '0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      outstanding <= '0;
      pending     <= '0;
      for (int i = 0; i < N; i++) nonce_q[i] <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tdata     <= '0;
      pkt_rep     <= 1'b0;
      pkt_idx     <= '0;
    end else begin
      s_tready <= state_nxt inside {IDLE, LOAD, FLUSH};
      if (beat && (state == IDLE || state == LOAD)) begin
        hdr_o[32*int'(widx) +: 32] <= s_tdata;
        widx <= hdr_end ? '0 : widx + IW'(1);
      end
      if (hdr_end) begin
        job_id    <= job_id + 8'd1;
        next_base <= '0;
        issued    <= '0;
        err_q     <= !hdr_ok;
        abort_q   <= 1'b0;
        found_cnt <= '0;
        drop_cnt  <= '0;
      end else begin
        if (|start_oh) begin
          next_base <= base_nxt;
          issued    <= issued + 32'd1;
        end
        if (state == DISPATCH && abort_i) abort_q <= 1'b1;
        found_cnt <= found_sum[8] ? 8'hFF : found_sum[7:0];
        drop_cnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
      outstanding <= (outstanding & ~hs_done) | start_oh;
      pending     <= (pending & ~pclr) | hs_found;
      for (int i = 0; i < N; i++)
        if (hs_found[i] && !drop[i]) nonce_q[i] <= hs_nonce[32*i +: 32];
      // one packet at a time; word1 is loaded on the word0 handshake
      if (m_hs && !m_tlast) begin
        m_tdata <= pkt_rep ? issued : sel_nonce;
        m_tlast <= 1'b1;
      end else if (m_end) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
        m_tdata  <= '0;
        pkt_rep  <= 1'b0;
      end else if (!m_tvalid) begin
        if (|pending) begin
          m_tvalid <= 1'b1;
          pkt_rep  <= 1'b0;
          pkt_idx  <= pend_idx;
          m_tdata  <= {4'h1, 4'h0, job_id, 12'h0, pend_idx};
        end else if (state == REPORT) begin
          m_tvalid <= 1'b1;
          pkt_rep  <= 1'b1;
          m_tdata  <= {rtype, 4'h0, job_id, found_cnt, drop_cnt};
        end
      end
    end
  end

endmodule

// File: tb/tb_miner_dispatch.sv
// tb_miner_dispatch: table-driven job vectors plus directed stall,
// drop, malformed-header and reset sequences against a hasher model.
module tb_miner_dispatch;
  localparam int N  = 2;
  localparam int HW = 19;
  localparam int CL = 28;

  logic              clk = 0;
  logic              rstn = 0;
  logic [31:0]       s_tdata = 0;
  logic              s_tvalid = 0;
  logic              s_tlast = 0;
  logic              s_tready;
  logic [31:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1;
  logic              abort_i = 0;
  logic              busy_o;
  logic [32*HW-1:0]  hdr_o;
  logic [N-1:0]      hs_start;
  logic [32*N-1:0]   hs_nonce_base;
  logic [N-1:0]      hs_done = 0;
  logic [N-1:0]      hs_found = 0;
  logic [32*N-1:0]   hs_nonce = 0;

  always #5 clk = ~clk;

  miner_dispatch #(.N_HASHERS(N), .HDR_WORDS(HW), .CHUNK_LOG2(CL)) dut (
    .clk(clk), .rstn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready),
    .abort_i(abort_i), .busy_o(busy_o), .hdr_o(hdr_o),
    .hs_start(hs_start), .hs_nonce_base(hs_nonce_base),
    .hs_done(hs_done), .hs_found(hs_found), .hs_nonce(hs_nonce)
  );

  typedef struct {
    int          found_chunk;
    logic [31:0] found_nonce;
    int          abort_after;
    int          exp_starts;
    int          exp_pkts;
    logic [31:0] exp_w [6];
  } vec_t;

  int passed = 0;
  int total = 0;

  // hasher / result model state
  int          timer [N];
  int          n_starts = 0;
  int          st_idx [$];
  logic [31:0] st_base [$];
  logic [32:0] rq [$];
  int          rp = 0;
  int          fc_chunk = -1;
  logic [31:0] fc_nonce = 0;
  int          fc_fire = -1;
  int          ab_after = -1;
  bit          ab_fire = 0;
  int          inj_req = 0;
  int          inj_ack = 0;
  logic [N-1:0] inj_mask = 0;
  logic [31:0] inj_n [N];
  int          stall_err = 0;
  bit          prev_stall = 0;
  logic [32:0] prev_word = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    hs_done  = '0;
    hs_found = '0;
    abort_i  = 1'b0;
    if (!rstn) begin
      for (int i = 0; i < N; i++) timer[i] = 0;
      fc_fire    = -1;
      ab_fire    = 0;
      prev_stall = 0;
    end else begin
      for (int i = 0; i < N; i++)
        if (timer[i] > 0) begin
          timer[i]--;
          if (timer[i] == 0) hs_done[i] = 1'b1;
        end
      if (fc_fire >= 0) begin
        hs_found[fc_fire] = 1'b1;
        hs_nonce[32*fc_fire +: 32] = fc_nonce;
        fc_fire = -1;
      end
      if (inj_req != inj_ack) begin
        inj_ack = inj_req;
        for (int i = 0; i < N; i++)
          if (inj_mask[i]) begin
            hs_found[i] = 1'b1;
            hs_nonce[32*i +: 32] = inj_n[i];
          end
      end
      if (ab_fire) begin
        abort_i = 1'b1;
        ab_fire = 0;
      end
      for (int i = 0; i < N; i++)
        if (hs_start[i]) begin
          st_idx.push_back(i);
          st_base.push_back(hs_nonce_base[32*i +: 32]);
          if (n_starts == fc_chunk) fc_fire = i;
          n_starts++;
          timer[i] = 3;
          if (n_starts == ab_after) ab_fire = 1;
        end
      if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} !== prev_word))
        stall_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) rq.push_back({m_tlast, m_tdata});
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_hdr(int nwords, int last_at);
    int b;
    for (int w = 0; w < nwords; w++) begin
      s_tdata  = 32'hA000_0000 + 32'(w);
      s_tvalid = 1'b1;
      s_tlast  = (w == last_at);
      b = 0;
      while (!s_tready && b < 50) begin
        tick(1);
        b++;
      end
      if (!s_tready) check("s_tready timeout", 0, 1);
      tick(1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_words(int n, output bit ok);
    int b = 0;
    while (rq.size() - rp < n && b < 600) begin
      tick(1);
      b++;
    end
    ok = (rq.size() - rp >= n);
    if (!ok) check("result words timeout", rq.size() - rp, n);
  endtask

  task automatic wait_starts(int target);
    int b = 0;
    while (n_starts < target && b < 200) begin
      tick(1);
      b++;
    end
    if (n_starts < target) check("start timeout", n_starts, target);
  endtask

  task automatic chk_words(string name, logic [31:0] w [6], int n);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s data w%0d", name, k), rq[rp+k][31:0], w[k]);
      check($sformatf("%s tlast w%0d", name, k), rq[rp+k][32], k % 2);
    end
    rp += n;
  endtask

  task automatic run_vec(string name, vec_t v);
    int s0;
    int q0;
    bit ok;
    s0 = n_starts;
    q0 = st_idx.size();
    fc_nonce = v.found_nonce;
    fc_chunk = (v.found_chunk >= 0) ? s0 + v.found_chunk : -1;
    ab_after = (v.abort_after > 0) ? s0 + v.abort_after : -1;
    send_hdr(HW, HW - 1);
    check({name, " first start"}, hs_start, 2'b01);
    check({name, " hdr w0"}, hdr_o[31:0], 32'hA000_0000);
    check({name, " hdr w18"}, hdr_o[32*18 +: 32], 32'hA000_0012);
    wait_words(2 * v.exp_pkts, ok);
    if (ok) chk_words(name, v.exp_w, 2 * v.exp_pkts);
    check({name, " starts"}, n_starts - s0, v.exp_starts);
    for (int k = 0; k < v.exp_starts && q0 + k < st_idx.size(); k++) begin
      check($sformatf("%s base%0d", name, k), st_base[q0+k], 32'(k) << CL);
      check($sformatf("%s hasher%0d", name, k), st_idx[q0+k], k % 2);
    end
    tick(3);
    check({name, " extra words"}, rq.size() - rp, 0);
    check({name, " busy idle"}, busy_o, 0);
    fc_chunk = -1;
    ab_after = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [3];
    vec_t v;
    logic [31:0] w [6];
    int s0;
    bit ok;

    vecs[0] = '{3, 32'h1234ABCD, 0, 16, 2,
               '{32'h10000001, 32'h1234ABCD, 32'h20000100, 32'h10,
                 32'h0, 32'h0}};
    vecs[1] = '{-1, 32'h0, 0, 16, 1,
               '{32'h20010000, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[2] = '{-1, 32'h0, 4, 4, 1,
               '{32'h40020000, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0}};

    #12;
    check("rst s_tready", s_tready, 0);
    check("rst m_tvalid", m_tvalid, 0);
    check("rst m_tlast", m_tlast, 0);
    check("rst m_tdata", m_tdata, 0);
    check("rst hs_start", hs_start, 0);
    check("rst base", hs_nonce_base, 0);
    check("rst hdr_o", |hdr_o, 0);
    check("rst busy", busy_o, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("s_tready at release", s_tready, 0);
    tick(1);
    check("s_tready rises", s_tready, 1);

    for (int i = 0; i < 3; i++) run_vec($sformatf("job%0d", i), vecs[i]);

    // both hashers find together while the result port is stalled
    m_tready = 1'b0;
    s0 = n_starts;
    send_hdr(HW, HW - 1);
    wait_starts(s0 + 2);
    inj_mask = 2'b11;
    inj_n[0] = 32'hAAAA_0000;
    inj_n[1] = 32'hBBBB_0000;
    inj_req++;
    for (int b = 0; b < 20 && !m_tvalid; b++) tick(1);
    s0 = stall_err;
    tick(5);
    check("stall tvalid", m_tvalid, 1);
    check("stall word0", m_tdata, 32'h10030000);
    check("stall stable", stall_err - s0, 0);
    m_tready = 1'b1;
    wait_words(6, ok);
    w = '{32'h10030000, 32'hAAAA_0000, 32'h10030001, 32'hBBBB_0000,
          32'h20030200, 32'h10};
    if (ok) chk_words("dual found", w, 6);

    // second found on a pending hasher is dropped
    m_tready = 1'b0;
    s0 = n_starts;
    send_hdr(HW, HW - 1);
    wait_starts(s0 + 2);
    inj_mask = 2'b01;
    inj_n[0] = 32'h1111_0000;
    inj_req++;
    tick(3);
    inj_n[0] = 32'h2222_0000;
    inj_req++;
    tick(3);
    m_tready = 1'b1;
    wait_words(4, ok);
    w = '{32'h10040000, 32'h1111_0000, 32'h20040201, 32'h10,
          32'h0, 32'h0};
    if (ok) chk_words("drop", w, 4);

    // tlast on word 10: error, no chunks
    s0 = n_starts;
    send_hdr(11, 10);
    wait_words(2, ok);
    w = '{32'h30050000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    if (ok) chk_words("early tlast", w, 2);
    check("early tlast starts", n_starts - s0, 0);

    // no tlast on word 18: flushed to tlast, error
    s0 = n_starts;
    send_hdr(21, 20);
    wait_words(2, ok);
    w = '{32'h30060000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    if (ok) chk_words("late tlast", w, 2);
    check("late tlast starts", n_starts - s0, 0);

    v = vecs[2];
    v.exp_w[0] = 32'h40070000;
    run_vec("after error", v);

    // reset in the middle of dispatch
    s0 = n_starts;
    send_hdr(HW, HW - 1);
    wait_starts(s0 + 3);
    rstn = 1'b0;
    #1;
    check("mid rst s_tready", s_tready, 0);
    check("mid rst m_tvalid", m_tvalid, 0);
    check("mid rst m_tlast", m_tlast, 0);
    check("mid rst m_tdata", m_tdata, 0);
    check("mid rst hs_start", hs_start, 0);
    check("mid rst base", hs_nonce_base, 0);
    check("mid rst hdr_o", |hdr_o, 0);
    check("mid rst busy", busy_o, 0);
    tick(2);
    rstn = 1'b1;
    check("mid rst s_tready hold", s_tready, 0);
    tick(1);
    check("mid rst s_tready rise", s_tready, 1);
    check("mid rst no packet", rq.size() - rp, 0);
    v = vecs[1];
    v.exp_w[0] = 32'h20000000;
    run_vec("after reset", v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
